// File: rtl/data_memory_pipe.sv
// Byte-addressed 32-bit data memory for the MEM stage: sub-word stores, extended
// sub-word loads through a READ_LATENCY-deep read pipeline, and a registered fault strobe.
module data_memory_pipe #(
    parameter int    ADDR_WIDTH   = 13,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "data.mif",
    parameter int    INIT_WORDS   = 256
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           writeData,
    input  logic                  memWrite,
    input  logic                  memRead,
    input  logic [1:0]            memSize,
    input  logic                  memUnsigned,
    output logic [31:0]           readData,
    output logic                  readValid,
    output logic                  memFault
);

    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic [31:0] word;
        logic [1:0]  lane;
        logic [1:0]  size;
        logic        uns;
    } beat_t;

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("data_memory_pipe: READ_LATENCY must be in 1..4");
    end
    if (INIT_FILE != "" && INIT_WORDS > DEPTH) begin : g_bad_init
        $error("data_memory_pipe: INIT_WORDS exceeds memory depth");
    end

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-3:0] word_idx;
    logic [1:0]            lane;
    logic                  misaligned;
    logic                  load_ok;
    logic                  store_ok;
    logic                  fault_req;
    logic [3:0]            be;
    logic [31:0]           wdata;

    logic [READ_LATENCY-1:0] valid_q;
    beat_t                   beat_q [READ_LATENCY];
    beat_t                   out_beat;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic [31:0]             ext;
    logic                    fault_q;

    assign word_idx = addr[ADDR_WIDTH-1:2];
    assign lane     = addr[1:0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        misaligned = 1'b1;
        case (memSize)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = addr[0];
            SIZE_WORD: misaligned = (addr[1:0] != 2'b00);
            default:   misaligned = 1'b1;
        endcase
    end

    assign load_ok   = resetn & memRead & ~memWrite & ~misaligned;
    assign store_ok  = resetn & memWrite & ~memRead & ~misaligned;
    assign fault_req = (memRead | memWrite) & ((memRead & memWrite) | misaligned);

    // Lane enables and lane-replicated store data; only enabled lanes are written.
    always_comb begin
        be    = 4'b0000;
        wdata = {4{writeData[7:0]}};
        case (memSize)
            SIZE_BYTE: be = 4'b0001 << lane;
            SIZE_HALF: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{writeData[15:0]}};
            end
            SIZE_WORD: begin
                be    = 4'b1111;
                wdata = writeData;
            end
            default: be = 4'b0000;
        endcase
    end

    // NOTE: the array and the data-carrying pipeline have no reset so they map onto block RAM
    // and plain flops; only the valid bits and the fault strobe are reset.
    always_ff @(posedge clk) begin
        if (store_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // The array is sampled only at the accept edge; later stages just carry the beat.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            beat_q[0] <= '{word: mem[word_idx], lane: lane, size: memSize, uns: memUnsigned};
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            beat_q[i] <= beat_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= '0;
            fault_q <= 1'b0;
        end else begin
            valid_q[0] <= load_ok;
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
            fault_q <= fault_req;
        end
    end

    assign out_beat = beat_q[READ_LATENCY-1];
    assign byte_sel = out_beat.word[{out_beat.lane, 3'b000} +: 8];
    assign half_sel = out_beat.lane[1] ? out_beat.word[31:16] : out_beat.word[15:0];

    always_comb begin
        ext = out_beat.word;
        case (out_beat.size)
            SIZE_BYTE: ext = {{24{~out_beat.uns & byte_sel[7]}}, byte_sel};
            SIZE_HALF: ext = {{16{~out_beat.uns & half_sel[15]}}, half_sel};
            default:   ext = out_beat.word;
        endcase
    end

    assign readValid = valid_q[READ_LATENCY-1];
    assign readData  = readValid ? ext : 32'h0;
    assign memFault  = fault_q;

endmodule

// File: tb/tb_data_memory_pipe.sv
// Randomised bench for data_memory_pipe: two instances (latency 1 and 3) share stimulus
// and are scored against a byte-array model with a cycle-keyed expectation table.
module tb_data_memory_pipe;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [12:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic        mem_unsigned = 1'b0;

    logic [31:0] rdata1, rdata3;
    logic        rvalid1, rvalid3, fault1, fault3;

    always #5 clk = ~clk;

    data_memory_pipe #(.ADDR_WIDTH(13), .READ_LATENCY(1), .INIT_FILE(""), .INIT_WORDS(0)) dut_l1 (
        .clk(clk), .resetn(resetn), .addr(addr), .writeData(wdata),
        .memWrite(mem_write), .memRead(mem_read), .memSize(mem_size),
        .memUnsigned(mem_unsigned), .readData(rdata1), .readValid(rvalid1),
        .memFault(fault1)
    );

    data_memory_pipe #(.ADDR_WIDTH(13), .READ_LATENCY(3), .INIT_FILE(""), .INIT_WORDS(0)) dut_l3 (
        .clk(clk), .resetn(resetn), .addr(addr), .writeData(wdata),
        .memWrite(mem_write), .memRead(mem_read), .memSize(mem_size),
        .memUnsigned(mem_unsigned), .readData(rdata3), .readValid(rvalid3),
        .memFault(fault3)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    logic [7:0]  ref_mem [0:8191];
    logic [31:0] exp1 [int];
    logic [31:0] exp3 [int];
    bit          fault_at [int];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h, expected %h", tag, edge_n, got, want);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [12:0] a, input logic [1:0] sz,
                                               input logic uns);
        int v;
        case (sz)
            2'd0: begin
                v = int'({24'b0, ref_mem[a]});
                if (!uns && v >= 128) v = v - 256;
            end
            2'd1: begin
                v = int'({24'b0, ref_mem[a]}) + 256 * int'({24'b0, ref_mem[a+1]});
                if (!uns && v >= 32768) v = v - 65536;
            end
            default: v = int'({ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]});
        endcase
        return v;
    endfunction

    // One clock: drive at the falling edge, predict, then score just after the rising edge.
    task automatic cycle(input logic rst_n, input logic rd, input logic wr,
                         input logic [12:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic uns);
        int  e;
        bit  legal;
        int  nbytes;
        logic [31:0] v;
        @(negedge clk);
        resetn = rst_n; mem_read = rd; mem_write = wr; addr = a;
        wdata = d; mem_size = sz; mem_unsigned = uns;
        e = edge_n + 1;
        legal = !(sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00));
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                exp1.delete(e + k);
                exp3.delete(e + k);
            end
        end else if ((rd || wr) && ((rd && wr) || !legal)) begin
            fault_at[e] = 1'b1;
        end else if (wr) begin
            nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            for (int i = 0; i < nbytes; i++) ref_mem[a + i] = d[8*i +: 8];
        end else if (rd) begin
            v = model_load(a, sz, uns);
            exp1[e]     = v;
            exp3[e + 2] = v;
        end
        @(posedge clk);
        edge_n = e;
        #1;
        check("valid_l1", {31'b0, rvalid1}, {31'b0, exp1.exists(e) != 0});
        check("data_l1",  rdata1, exp1.exists(e) ? exp1[e] : 32'h0);
        check("fault_l1", {31'b0, fault1}, {31'b0, fault_at.exists(e) != 0});
        check("valid_l3", {31'b0, rvalid3}, {31'b0, exp3.exists(e) != 0});
        check("data_l3",  rdata3, exp3.exists(e) ? exp3[e] : 32'h0);
        check("fault_l3", {31'b0, fault3}, {31'b0, fault_at.exists(e) != 0});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 13'($urandom), $urandom, 2'($urandom), 1'($urandom));
        end
    endtask

    task automatic store(input logic [12:0] a, input logic [31:0] d, input logic [1:0] sz);
        cycle(1'b1, 1'b0, 1'b1, a, d, sz, 1'b0);
    endtask

    task automatic load(input logic [12:0] a, input logic [1:0] sz, input logic uns);
        cycle(1'b1, 1'b1, 1'b0, a, 32'h0, sz, uns);
    endtask

    initial begin
        logic [12:0] a;
        logic [1:0]  sz;
        int          op;

        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);

        // Known contents for the whole test window; words 0..3 hold 0..3.
        for (int w = 0; w < 64; w++) store(13'(w * 4), (w < 4) ? 32'(w) : $urandom, 2'd2);

        store(13'h010, 32'hDEADBEEF, 2'd2);
        load(13'h010, 2'd2, 1'b0);
        idle(3);

        store(13'h020, 32'h80FF7F01, 2'd2);
        store(13'h022, 32'h000000AA, 2'd0);
        load(13'h020, 2'd2, 1'b0);
        load(13'h023, 2'd0, 1'b0);
        load(13'h023, 2'd0, 1'b1);
        load(13'h020, 2'd1, 1'b0);
        load(13'h022, 2'd1, 1'b0);
        idle(3);

        store(13'h021, 32'h0000BEEF, 2'd1);
        load(13'h020, 2'd2, 1'b0);
        load(13'h022, 2'd2, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 13'h020, 32'h0, 2'd2, 1'b0);
        load(13'h020, 2'd2, 1'b0);
        load(13'h024, 2'd3, 1'b0);
        idle(3);

        for (int i = 0; i < 4; i++) load(13'(i * 4), 2'd2, 1'b0);
        idle(3);

        store(13'h040, 32'h12345678, 2'd2);
        load(13'h040, 2'd2, 1'b0);
        idle(3);

        load(13'h040, 2'd2, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 13'h040, 32'hFFFFFFFF, 2'd2, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 13'h000, 32'h0, 2'd0, 1'b0);
        idle(4);
        load(13'h040, 2'd2, 1'b0);
        idle(3);

        for (int n = 0; n < 3000; n++) begin
            op = $urandom_range(0, 99);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 13'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            if (op < 2)
                cycle(1'b0, 1'($urandom), 1'($urandom), a, $urandom, sz, 1'($urandom));
            else if (op < 40)
                cycle(1'b1, 1'b1, 1'b0, a, $urandom, sz, 1'($urandom));
            else if (op < 70)
                cycle(1'b1, 1'b0, 1'b1, a, $urandom, sz, 1'($urandom));
            else if (op < 75)
                cycle(1'b1, 1'b1, 1'b1, a, $urandom, sz, 1'($urandom));
            else
                idle(1);
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
